// File: rtl/fpu_i2f_if.sv
// Operand/result bundle for the int32 -> fp32 converter.
// Master drives EN/START/A; slave returns BUSY/DONE/Z (no backpressure, START ignored while BUSY).
interface fpu_i2f_if;
  logic        EN;
  logic        START;
  logic [31:0] A;
  logic        BUSY;
  logic        DONE;
  logic [31:0] Z;

  modport master (output EN, START, A, input BUSY, DONE, Z);
  modport slave  (input EN, START, A, output BUSY, DONE, Z);
endinterface

// File: rtl/fpu_i2f.sv
// Signed int32 to IEEE-754 single conversion, round-to-nearest-even, one bit of normalisation per cycle.
// Latency lz+2 enabled cycles (0 for A=0); EN=0 freezes everything; START while BUSY is dropped.
module fpu_i2f (
  input  logic       CLK,
  input  logic       RESET,
  fpu_i2f_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] z_q, z_d;
  logic        done_q, done_d;

  logic [31:0] a_mag;
  logic [22:0] frac_trunc;
  logic        guard, sticky, round_up;
  logic [23:0] frac_sum;
  logic [7:0]  exp_rnd;
  logic [22:0] frac_rnd;

  // Two's-complement negate also maps INT_MIN onto 0x80000000, which is its magnitude.
  assign a_mag      = bus.A[31] ? (~bus.A + 32'd1) : bus.A;

  assign frac_trunc = mag_q[30:8];
  assign guard      = mag_q[7];
  assign sticky     = |mag_q[6:0];
  assign round_up   = guard & (sticky | mag_q[8]);
  assign frac_sum   = {1'b0, frac_trunc} + {23'd0, round_up};
  assign exp_rnd    = exp_q + {7'd0, frac_sum[23]};
  assign frac_rnd   = frac_sum[23] ? 23'd0 : frac_sum[22:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else if (bus.EN) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.START && (bus.A != 32'd0)) begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end
      end
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sign_d = sign_q;
    mag_d  = mag_q;
    exp_d  = exp_q;
    z_d    = z_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (bus.A == 32'd0) begin
            z_d    = 32'd0;
            done_d = 1'b1;
          end else begin
            sign_d = bus.A[31];
            mag_d  = a_mag;
            exp_d  = 8'd158;
          end
        end
      end
      NORM: begin
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      ROUND: begin
        exp_d  = exp_rnd;
        z_d    = {sign_q, exp_rnd, frac_rnd};
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sign_q <= 1'b0;
      mag_q  <= 32'd0;
      exp_q  <= 8'd0;
      z_q    <= 32'd0;
      done_q <= 1'b0;
    end else if (bus.EN) begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
      exp_q  <= exp_d;
      z_q    <= z_d;
      done_q <= done_d;
    end
  end

  assign bus.BUSY = (state_q != IDLE);
  assign bus.DONE = done_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_fpu_i2f.sv
// Randomised bench for fpu_i2f against a cycle-count/arith reference, plus directed corner cases.
module tb_fpu_i2f;

  logic clk;
  logic rst;
  fpu_i2f_if bus ();

  fpu_i2f dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int msb_pos(input longint unsigned m);
    int p = -1;
    for (int i = 0; i < 40; i++)
      if (m >= (64'd1 << i)) p = i;
    return p;
  endfunction

  function automatic longint unsigned magnitude(input logic [31:0] a);
    if (a[31]) return 64'h1_0000_0000 - {32'd0, a};
    return {32'd0, a};
  endfunction

  // Reference conversion from the real value: scale to 24 significant bits, round half to even.
  function automatic logic [31:0] i2f(input logic [31:0] a);
    longint unsigned m, q, rem, half;
    int p, sh;
    if (a == 32'd0) return 32'd0;
    m = magnitude(a);
    p = msb_pos(m);
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (q & 64'd1) == 64'd1)) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    return {a[31], 8'(127 + p), q[22:0]};
  endfunction

  // Model: edges remaining until DONE; result published when the count reaches zero.
  int          m_cnt  = 0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_z    = 32'd0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  = 0;
      m_z    = 32'd0;
      m_done = 1'b0;
    end else if (bus.EN) begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_z    = m_pend;
        end
      end else if (bus.START) begin
        if (bus.A == 32'd0) begin
          m_done = 1'b1;
          m_z    = 32'd0;
        end else begin
          m_pend = i2f(bus.A);
          m_cnt  = (31 - msb_pos(magnitude(bus.A))) + 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("busy", {31'd0, bus.BUSY}, {31'd0, (m_cnt > 0)});
      chk("done", {31'd0, bus.DONE}, {31'd0, m_done});
      chk("z",    bus.Z, m_z);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one START and count enabled edges until DONE.
  task automatic run_one(input string name, input logic [31:0] a, input int exp_lat,
                         input logic [31:0] exp_z);
    int n = 0;
    bus.A     = a;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    while (!bus.DONE && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_z"}, bus.Z, exp_z);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    bus.EN    = 1'b1;
    bus.START = 1'b0;
    bus.A     = 32'd0;

    chk("ref_one",   i2f(32'd1), 32'h3F80_0000);
    chk("ref_m5",    i2f(-32'sd5), 32'hC0A0_0000);
    chk("ref_max",   i2f(32'h7FFF_FFFF), 32'h4F00_0000);
    chk("ref_min",   i2f(32'h8000_0000), 32'hCF00_0000);
    chk("ref_tie_e", i2f(32'd16777217), 32'h4B80_0000);
    chk("ref_tie_o", i2f(32'd16777219), 32'h4B80_0002);

    tick();
    tick();
    checking = 1'b1;
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_z", bus.Z, 32'd0);
    rst = 1'b0;

    run_one("one",   32'd1, 33, 32'h3F80_0000);
    run_one("m5",    -32'sd5, 31, 32'hC0A0_0000);
    run_one("zero",  32'd0, 0, 32'h0000_0000);
    run_one("max",   32'h7FFF_FFFF, 3, 32'h4F00_0000);
    run_one("min",   32'h8000_0000, 2, 32'hCF00_0000);
    run_one("tie_e", 32'd16777217, 9, 32'h4B80_0000);
    run_one("tie_o", 32'd16777219, 9, 32'h4B80_0002);
    run_one("b2b",   32'd3, 32, 32'h4040_0000);

    // EN stall of 5 cycles mid-NORM plus an ignored START while busy.
    bus.A     = 32'd1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    n = 0;
    repeat (10) begin tick(); n++; end
    bus.EN = 1'b0;
    bus.A  = 32'd7;
    bus.START = 1'b1;
    repeat (5) begin tick(); n++; end
    bus.EN = 1'b1;
    tick(); n++;
    bus.START = 1'b0;
    while (!bus.DONE && n < 100) begin tick(); n++; end
    chk("stall_lat", n, 38);
    chk("stall_z", bus.Z, 32'h3F80_0000);
    tick();

    // Reset during NORM aborts, then START right after reset is accepted.
    bus.A     = 32'd1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("abort_done", {31'd0, bus.DONE}, 32'd0);
    chk("abort_z", bus.Z, 32'd0);
    run_one("post_rst", -32'sd5, 31, 32'hC0A0_0000);

    repeat (5000) begin
      case ($urandom_range(0, 5))
        0: bus.A = $urandom;
        1: bus.A = $urandom_range(0, 255);
        2: bus.A = 32'h8000_0000;
        3: bus.A = 32'd0;
        4: bus.A = $urandom >> $urandom_range(0, 31);
        default: bus.A = -($urandom >> $urandom_range(0, 31));
      endcase
      bus.EN    = ($urandom_range(0, 9) < 8);
      bus.START = ($urandom_range(0, 9) < 3);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst       = 1'b0;
    bus.EN    = 1'b1;
    bus.START = 1'b0;
    repeat (40) tick();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fpu_i2f.md
FPU_I2F -- requirements
Module: fpu_i2f

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have: RESET  in  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 SHALL have: EN  in  1  clock enable; when 0, all internal state and outputs hold.
REQ-004 SHALL have: START  in  1  request to convert A; sampled only in IDLE with EN=1.
REQ-005 SHALL have: A  in  32  signed two's-complement integer operand.
REQ-006 SHALL have: BUSY  out  1  high while a conversion is in progress (not IDLE).
REQ-007 SHALL have: DONE  out  1  registered one-cycle pulse; Z valid when high.
REQ-008 SHALL have: Z  out  32  registered IEEE-754 single-precision result; holds until next DONE.

Function
REQ-009 SHALL convert A to FP32, rounding to nearest, ties to even; the result is the FP32 value an operand producer feeds the team's fpu_add.
REQ-010 SHALL implement FSM states IDLE, NORM and ROUND; BUSY=1 in NORM and ROUND.
REQ-011 IDLE, EN=1, START=1, A!=0 -> capture sign=A[31], MAG=|A| as 32-bit unsigned, EXP=158; next state NORM.
REQ-012 IDLE, EN=1, START=1, A=0 -> Z<=0x00000000, DONE pulse on the same edge; remain IDLE.
REQ-013 NORM, each EN=1 edge: if MAG[31]=0 -> MAG<<=1, EXP-=1, stay NORM; else -> ROUND.
REQ-014 NORM SHALL occupy exactly lz+1 enabled cycles, where lz = leading zeros of |A| (0..31).
REQ-015 ROUND: fraction=MAG[30:8], guard=MAG[7], sticky=OR(MAG[6:0]); increment if guard & (sticky | MAG[8]).
REQ-016 On fraction carry-out, ROUND SHALL set fraction=0 and EXP+=1.
REQ-017 The ROUND edge SHALL register Z={sign,EXP[7:0],fraction} and DONE=1, then return to IDLE.
REQ-018 Latency: START edge k -> DONE high after edge k+lz+2 (enabled edges); A=0 -> after edge k.
REQ-019 DONE SHALL be high exactly one enabled cycle and clear on the next enabled edge.
REQ-020 START while BUSY=1 SHALL be ignored; no queuing; A is not re-sampled after capture.
REQ-021 START in the cycle DONE is high (FSM in IDLE) SHALL be accepted normally (back-to-back).
REQ-022 A=0x80000000 (INT_MIN) SHALL give MAG=0x80000000, lz=0, Z=0xCF000000.
REQ-023 EN=0 SHALL freeze FSM, MAG, EXP, BUSY, DONE and Z; START is ignored; a high DONE stays high until the next enabled edge.
REQ-024 EXP SHALL be 8 bits wide; results never overflow or denormalize (range 2^0..2^31).

Reset
REQ-025 RESET=1 at a rising edge SHALL force IDLE, BUSY=0, DONE=0, Z=0x00000000, MAG=0, EXP=0, regardless of EN or START.
REQ-026 RESET mid-conversion SHALL abort it with no DONE pulse; a START is accepted on the first edge after RESET deasserts.

Verification
REQ-027 A=1, START one cycle -> 32 NORM cycles; DONE after edge k+33; Z=0x3F800000.
REQ-028 A=-5 -> Z=0xC0A00000; A=0 -> Z=0x00000000, DONE after edge k, BUSY stays 0.
REQ-029 A=0x7FFFFFFF -> round-up carry, Z=0x4F000000; A=0x80000000 -> Z=0xCF000000, DONE after edge k+2.
REQ-030 A=16777217 (tie, even LSB) -> Z=0x4B800000; A=16777219 (tie, odd LSB) -> Z=0x4B800002.
REQ-031 Conversion of A=1 with EN=0 for 5 mid-NORM cycles -> DONE delayed by exactly 5 cycles; extra START while BUSY ignored; Z=0x3F800000.
REQ-032 RESET pulsed during NORM -> no DONE; Z=0; BUSY=0; next START with A=-5 yields Z=0xC0A00000.
